// File: rtl/reg_file_pkg.sv
// mips_pkg: constants shared by the register file, the instruction decoder
// and the RegDst mux.
//   REG_ADDR_W / REG_DATA_W : default register address / data widths
//   REG_ZERO / REG_SP / REG_RA : architectural register numbers
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 29;
    localparam int unsigned REG_RA   = 31;

    // Depth of a register array addressed by aw bits.
    function automatic int unsigned reg_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: register-file bus between the datapath (master) and reg_file
// (slave).
//   RSaddr_in/RTaddr_in  -> read addresses for the two ALU operand ports
//   RDaddr_in/RDdata_in/RegWrite_in -> write port from the write-back mux
//   DBGaddr_in           -> debug read address
//   RSdata_out/RTdata_out/DBGdata_out <- combinational read data
interface reg_file_if
    import mips_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
);
    logic [ADDR_W-1:0] RSaddr_in;
    logic [ADDR_W-1:0] RTaddr_in;
    logic [ADDR_W-1:0] RDaddr_in;
    logic [DATA_W-1:0] RDdata_in;
    logic              RegWrite_in;
    logic [ADDR_W-1:0] DBGaddr_in;
    logic [DATA_W-1:0] RSdata_out;
    logic [DATA_W-1:0] RTdata_out;
    logic [DATA_W-1:0] DBGdata_out;

    modport master (
        output RSaddr_in, RTaddr_in, RDaddr_in, RDdata_in, RegWrite_in, DBGaddr_in,
        input  RSdata_out, RTdata_out, DBGdata_out
    );

    modport slave (
        input  RSaddr_in, RTaddr_in, RDaddr_in, RDdata_in, RegWrite_in, DBGaddr_in,
        output RSdata_out, RTdata_out, DBGdata_out
    );
endinterface

// File: rtl/reg_file_reg_read_port.sv
// reg_read_port: one combinational read port of the register file.
//   i_addr     : read address
//   i_regs     : stored registers 1..DEPTH-1 (register 0 is not stored)
//   i_wr_en    : qualified write strobe (RegWrite, not in reset, addr != 0)
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   o_data     : read data; 0 for address 0, optionally forwards i_wr_data
module reg_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter bit BYPASS = 1'b0
) (
    input  logic [ADDR_W-1:0]                    i_addr,
    input  logic [(2**ADDR_W)-1:1][DATA_W-1:0]   i_regs,
    input  logic                                 i_wr_en,
    input  logic [ADDR_W-1:0]                    i_wr_addr,
    input  logic [DATA_W-1:0]                    i_wr_data,
    output logic [DATA_W-1:0]                    o_data
);
    logic              w_is_zero;
    logic [DATA_W-1:0] w_stored;

    assign w_is_zero = (i_addr == ADDR_W'(REG_ZERO));
    assign w_stored  = w_is_zero ? '0 : i_regs[i_addr];

    generate
        if (BYPASS) begin : g_bypass
            // i_wr_en already excludes address 0 and reset, so a match here
            // can never forward into r0 or during reset.
            logic w_hit;
            assign w_hit  = i_wr_en && (i_addr == i_wr_addr);
            assign o_data = w_hit ? i_wr_data : w_stored;
        end else begin : g_no_bypass
            logic w_unused;
            assign w_unused = ^{i_wr_en, i_wr_addr, i_wr_data};
            assign o_data   = w_stored;
        end
    endgenerate
endmodule

// File: rtl/reg_file.sv
// reg_file: 2R1W general-purpose register file with a debug read port.
//   clk_in  : clock, state updates on the rising edge
//   rst_in  : synchronous active-high reset, clears every stored register
//   bus     : reg_file_if slave (read/write addresses, write data/enable,
//             RS/RT/DBG read data)
// Register 0 reads as zero and is never stored. Reads are combinational.
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter bit BYPASS = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    reg_file_if.slave  bus
);
    localparam int DEPTH = int'(reg_depth(ADDR_W));

    logic [DEPTH-1:1][DATA_W-1:0] r_regs;
    logic                         w_wr_en;

    // Single qualified strobe used by both storage and bypass so that reset
    // and address-0 rules stay identical in both places. RegWrite_in = 0
    // forces it low even if address/data are unknown.
    assign w_wr_en = bus.RegWrite_in && !rst_in &&
                     (bus.RDaddr_in != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_regs <= '0;
        end else if (w_wr_en) begin
            r_regs[bus.RDaddr_in] <= bus.RDdata_in;
        end
    end

    logic [2:0][ADDR_W-1:0] w_rd_addr;
    logic [2:0][DATA_W-1:0] w_rd_data;

    assign w_rd_addr = {bus.DBGaddr_in, bus.RTaddr_in, bus.RSaddr_in};

    reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd_port [2:0] (
        .i_addr    (w_rd_addr),
        .i_regs    (r_regs),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (bus.RDaddr_in),
        .i_wr_data (bus.RDdata_in),
        .o_data    (w_rd_data)
    );

    assign bus.RSdata_out  = w_rd_data[0];
    assign bus.RTdata_out  = w_rd_data[1];
    assign bus.DBGdata_out = w_rd_data[2];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed bench driving two reg_file instances in parallel,
// one with BYPASS = 0 (u_nb) and one with BYPASS = 1 (u_bp).
module tb_reg_file;
    import mips_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [4:0]  rs_a, rt_a, rd_a, dbg_a;
    logic [31:0] rd_d;
    logic        we;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus_nb ();
    reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus_bp ();

    assign bus_nb.RSaddr_in   = rs_a;
    assign bus_nb.RTaddr_in   = rt_a;
    assign bus_nb.RDaddr_in   = rd_a;
    assign bus_nb.RDdata_in   = rd_d;
    assign bus_nb.RegWrite_in = we;
    assign bus_nb.DBGaddr_in  = dbg_a;
    assign bus_bp.RSaddr_in   = rs_a;
    assign bus_bp.RTaddr_in   = rt_a;
    assign bus_bp.RDaddr_in   = rd_a;
    assign bus_bp.RDdata_in   = rd_d;
    assign bus_bp.RegWrite_in = we;
    assign bus_bp.DBGaddr_in  = dbg_a;

    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nb (
        .clk_in (clk_in), .rst_in (rst_in), .bus (bus_nb.slave));
    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_bp (
        .clk_in (clk_in), .rst_in (rst_in), .bus (bus_bp.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then let combinational reads settle.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in = 1'b1; we = 1'b0; rs_a = '0; rt_a = '0; rd_a = '0; rd_d = '0; dbg_a = '0;
        tick();
        rst_in = 1'b0;

        // reset state
        rs_a = 5'd7; rt_a = 5'd31; #1;
        chk("rst_rs_nb", bus_nb.RSdata_out, 32'h0);
        chk("rst_rt_bp", bus_bp.RTdata_out, 32'h0);

        // reset clears a written register
        we = 1'b1; rd_a = 5'd5; rd_d = 32'hDEADBEEF; tick();
        we = 1'b0; rs_a = 5'd5; #1;
        chk("r5_pre_rst_nb", bus_nb.RSdata_out, 32'hDEADBEEF);
        chk("r5_pre_rst_bp", bus_bp.RSdata_out, 32'hDEADBEEF);
        rst_in = 1'b1; tick(); rst_in = 1'b0; #1;
        chk("r5_post_rst_nb", bus_nb.RSdata_out, 32'h0);
        chk("r5_post_rst_bp", bus_bp.RSdata_out, 32'h0);
        for (int a = 0; a < 32; a++) begin
            dbg_a = 5'(a); #1;
            chk($sformatf("dbg_rst_nb[%0d]", a), bus_nb.DBGdata_out, 32'h0);
            chk($sformatf("dbg_rst_bp[%0d]", a), bus_bp.DBGdata_out, 32'h0);
        end

        // write/read on consecutive edges, ALU sub of the two operands
        we = 1'b1; rd_a = 5'd8; rd_d = 32'h00000007; tick();
        rd_a = 5'd9; rd_d = 32'hFFFFFFF9; tick();
        we = 1'b0; rs_a = 5'd8; rt_a = 5'd9; #1;
        chk("r8_nb", bus_nb.RSdata_out, 32'h00000007);
        chk("r9_nb", bus_nb.RTdata_out, 32'hFFFFFFF9);
        chk("r8_bp", bus_bp.RSdata_out, 32'h00000007);
        chk("r9_bp", bus_bp.RTdata_out, 32'hFFFFFFF9);
        chk("alu_sub", bus_nb.RSdata_out - bus_nb.RTdata_out, 32'h0000000E);

        // r0 immutable, no forwarding to r0
        we = 1'b1; rd_a = 5'(REG_ZERO); rd_d = 32'h12345678; rs_a = 5'd0; #1;
        chk("r0_same_cyc_bp", bus_bp.RSdata_out, 32'h0);
        tick(); we = 1'b0; #1;
        chk("r0_after_nb", bus_nb.RSdata_out, 32'h0);
        chk("r0_after_bp", bus_bp.RSdata_out, 32'h0);

        // write disabled keeps prior value; unknown address/data also harmless
        we = 1'b1; rd_a = 5'd3; rd_d = 32'h00000001; tick();
        we = 1'b0; rd_a = 5'd3; rd_d = 32'hAAAA5555; dbg_a = 5'd3; #1;
        chk("wdis_same_cyc_bp", bus_bp.DBGdata_out, 32'h00000001);
        tick();
        chk("wdis_nb", bus_nb.DBGdata_out, 32'h00000001);
        chk("wdis_bp", bus_bp.DBGdata_out, 32'h00000001);
        rd_a = 'x; rd_d = 'x; tick();
        chk("wdis_x_nb", bus_nb.DBGdata_out, 32'h00000001);
        chk("r8_x_bp", bus_bp.RSdata_out, 32'h0);

        // same-cycle read of the write target
        we = 1'b1; rd_a = 5'd10; rd_d = 32'h11111111; tick();
        rd_d = 32'h22222222; rs_a = 5'd10; rt_a = 5'd10; #1;
        chk("sc_rs_pre_nb", bus_nb.RSdata_out, 32'h11111111);
        chk("sc_rt_pre_nb", bus_nb.RTdata_out, 32'h11111111);
        chk("sc_rs_pre_bp", bus_bp.RSdata_out, 32'h22222222);
        chk("sc_rt_pre_bp", bus_bp.RTdata_out, 32'h22222222);
        tick(); we = 1'b0; #1;
        chk("sc_rs_post_nb", bus_nb.RSdata_out, 32'h22222222);
        chk("sc_rt_post_nb", bus_nb.RTdata_out, 32'h22222222);
        chk("sc_rs_post_bp", bus_bp.RSdata_out, 32'h22222222);

        // bypass on the debug port only, RS/RT looking elsewhere
        we = 1'b1; rd_a = 5'(REG_SP); rd_d = 32'h0BADF00D; dbg_a = 5'(REG_SP); #1;
        chk("dbg_byp_nb", bus_nb.DBGdata_out, 32'h0);
        chk("dbg_byp_bp", bus_bp.DBGdata_out, 32'h0BADF00D);
        chk("rs_nobyp_bp", bus_bp.RSdata_out, 32'h22222222);
        tick();

        // back-to-back writes to the same address
        rd_a = 5'(REG_RA); rd_d = 32'h000000AA; tick();
        rd_d = 32'h000000BB; tick();
        we = 1'b0; dbg_a = 5'(REG_RA); #1;
        chk("b2b_nb", bus_nb.DBGdata_out, 32'h000000BB);
        chk("b2b_bp", bus_bp.DBGdata_out, 32'h000000BB);

        // reset vs write collision: write dropped, no forwarding under reset
        we = 1'b1; rd_a = 5'd4; rd_d = 32'h00000055; tick();
        rst_in = 1'b1; rd_d = 32'hCAFEF00D; rs_a = 5'd4; #1;
        chk("coll_pre_nb", bus_nb.RSdata_out, 32'h00000055);
        chk("coll_pre_bp", bus_bp.RSdata_out, 32'h00000055);
        tick(); rst_in = 1'b0; we = 1'b0; #1;
        chk("coll_post_nb", bus_nb.RSdata_out, 32'h0);
        chk("coll_post_bp", bus_bp.RSdata_out, 32'h0);
        dbg_a = 5'(REG_RA); #1;
        chk("coll_r31_nb", bus_nb.DBGdata_out, 32'h0);
        chk("coll_r31_bp", bus_bp.DBGdata_out, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Sits directly upstream of the ALU: its two read ports drive the ALU's two operand inputs (rs, and rt via the ALUSrc mux).
- The single write port is fed by the write-back mux (ALU result or memory data) and is gated by RegWrite.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register and port data width.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- BYPASS, 0, 1 = write-to-read forwarding in the same cycle; 0 = reads show the pre-write value.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- RSaddr_in  input  ADDR_W  read port 1 address (instr[25:21]).
- RTaddr_in  input  ADDR_W  read port 2 address (instr[20:16]).
- RDaddr_in  input  ADDR_W  write address (rd or rt, from the RegDst mux).
- RDdata_in  input  DATA_W  write data.
- RegWrite_in  input  1  write enable.
- RSdata_out  output  DATA_W  read port 1 data, drives ALU data1_in.
- RTdata_out  output  DATA_W  read port 2 data, goes to the ALUSrc mux and then ALU data2_in.
- DBGaddr_in  input  ADDR_W  debug/testbench read address.
- DBGdata_out  output  DATA_W  debug read data.

Behaviour:
- Storage: registers 1..(2**ADDR_W - 1), each DATA_W wide. Register 0 is not stored.
- Reset:
  - On a rising edge with rst_in = 1, every stored register becomes 0.
  - Reset has priority over a simultaneous write; that write is dropped.
  - Because reads are combinational, all read outputs show 0 from the cycle after the reset edge.
- Write:
  - Occurs on a rising edge when rst_in = 0, RegWrite_in = 1 and RDaddr_in != 0.
  - reg[RDaddr_in] <= RDdata_in.
  - A write to address 0 is silently ignored.
  - Write latency is 1 edge.
- Read:
  - Purely combinational, zero latency, as the single-cycle datapath requires.
  - Address 0 always returns 0, regardless of any write attempt.
  - Otherwise the port returns the current value of reg[addr].
  - RSaddr_in and RTaddr_in are independent. Both ports may address the same register and then return identical data.
- Bypass, BYPASS = 1:
  - Applies to a read port when RegWrite_in = 1, rst_in = 0, RDaddr_in != 0 and the port address equals RDaddr_in.
  - That port returns RDdata_in in the same cycle, before the edge.
  - Applies independently to RS, RT and DBG.
  - Never applies to address 0.
  - Never applies while rst_in = 1; the port then returns the stored value.
- No bypass, BYPASS = 0: a read in the write cycle returns the old value; the new value is visible after the edge.
- Back-to-back writes to the same address: the last write wins, one write per edge.
- X-safety: with RegWrite_in = 0, no register changes, whatever the values of RDaddr_in or RDdata_in (including X).
- Reset mid-program: all register contents are lost. No partial state is retained.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ADDR_W = 5, REG_DATA_W = 32.
  - Named register constants: REG_ZERO = 0, REG_SP = 29, REG_RA = 31.
  - These are also used by the decoder and the RegDst mux.
- One sub-module is natural: reg_read_port.
  - Does the zero-check, array select and optional bypass compare.
  - Instantiated three times (RS, RT, DBG) with BYPASS passed down.
- Write logic and storage stay in reg_file.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then assert rst_in for 1 edge -> RSdata_out = 0 for RSaddr_in = 5, and DBGdata_out = 0 for every address 0..31.
- Write/read: write 0x00000007 to r8 and 0xFFFFFFF9 to r9 on consecutive edges; set RSaddr_in = 8, RTaddr_in = 9 -> RSdata_out = 0x00000007, RTdata_out = 0xFFFFFFF9 (feeding the ALU with sub gives 0x0000000E).
- r0 immutable: RegWrite_in = 1, RDaddr_in = 0, RDdata_in = 0x12345678 -> after the edge RSdata_out = 0 for address 0; also 0 in the same cycle with BYPASS = 1.
- Write disabled: RegWrite_in = 0, RDaddr_in = 3, RDdata_in = 0xAAAA5555 -> r3 keeps its prior value 0x00000001.
- Same-cycle read of the write target:
  - Precondition: r10 = 0x11111111.
  - Stimulus: write 0x22222222 to r10 while RSaddr_in = RTaddr_in = 10.
  - BYPASS = 0 -> both ports show 0x11111111 before the edge and 0x22222222 after.
  - BYPASS = 1 -> both ports show 0x22222222 before the edge.
- Reset vs write collision: rst_in = 1 and RegWrite_in = 1 to r4 with 0xCAFEF00D on the same edge -> r4 = 0 afterwards; with BYPASS = 1, no forwarding during that cycle.
